// File: rtl/fse_filter.sv
// rtl/fse_filter.sv - T/2 complex FIR equalizer with QPSK slicer, error and LMS strobes
// Define FSE_STARTUP_HOLD_EN to hold o_en_taps low for HOLD_SYMS baud symbols after reset/enable.
module fse_filter #(
   parameter int                       NUM_TAPS  = 9,
   parameter int                       NBT_IN    = 8,
   parameter int                       NBF_IN    = 7,
   parameter int                       NBT_TAPS  = 28,
   parameter int                       NBF_TAPS  = 25,
   parameter int                       NBT_OUT   = 12,
   parameter int                       NBF_OUT   = 9,
   parameter int                       NBT_ERR   = 12,
   parameter int                       NBF_ERR   = 9,
   parameter logic signed [NBT_OUT-1:0] DEC_LVL  = 12'sd362,
   parameter int                       HOLD_SYMS = 16
) (
   input  logic                         clk,
   input  logic                         i_reset_n,
   input  logic                         i_en_rx,
   input  logic                         i_valid,
   input  logic [NBT_IN-1:0]            i_data_I,
   input  logic [NBT_IN-1:0]            i_data_Q,
   input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_I,
   input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_Q,
   output logic [NBT_OUT-1:0]           o_y_I,
   output logic [NBT_OUT-1:0]           o_y_Q,
   output logic                         o_y_valid,
   output logic                         o_dec_I,
   output logic                         o_dec_Q,
   output logic [NBT_ERR-1:0]           o_err_I,
   output logic [NBT_ERR-1:0]           o_err_Q,
   output logic                         o_en_shtr,
   output logic                         o_save_shftrs,
   output logic                         o_en_taps,
   output logic                         o_overrun
);

   localparam int PROD_W     = NBT_TAPS + NBT_IN;
   localparam int SUM_W      = PROD_W + 1;
   localparam int ACC_W      = SUM_W + $clog2(NUM_TAPS);
   localparam int SHIFT      = NBF_TAPS + NBF_IN - NBF_OUT;
   localparam int TRUNC_W    = ACC_W - SHIFT;
   localparam int ERR_CALC_W = NBT_OUT + 1;
   localparam int ERR_SHIFT  = NBF_OUT - NBF_ERR;
   localparam int HCNT_W     = $clog2(HOLD_SYMS + 1);
`ifdef FSE_STARTUP_HOLD_EN
   localparam int HOLD_LEN   = HOLD_SYMS;
`else
   localparam int HOLD_LEN   = 0;
`endif

   logic signed [NBT_IN-1:0]     sh_I  [NUM_TAPS];
   logic signed [NBT_IN-1:0]     sh_Q  [NUM_TAPS];
   logic signed [NBT_IN-1:0]     win_I [NUM_TAPS];
   logic signed [NBT_IN-1:0]     win_Q [NUM_TAPS];
   logic signed [SUM_W-1:0]      sum_I [NUM_TAPS];
   logic signed [SUM_W-1:0]      sum_Q [NUM_TAPS];
   logic signed [ACC_W-1:0]      acc_I, acc_Q;
   logic        [TRUNC_W-1:0]    tr_I, tr_Q;
   logic signed [NBT_OUT-1:0]    y_I, y_Q;
   logic signed [ERR_CALC_W-1:0] d_I, d_Q, e_I, e_Q;
   logic [NBT_ERR-1:0]           err_I, err_Q;
   logic                         dec_I, dec_Q;
   logic                         acc_d, phase, accept, baud;
   logic                         y_valid, en_taps, overrun;
   logic [HCNT_W-1:0]            hold_cnt;

   function automatic logic [NBT_OUT-1:0] sat_y(input logic [TRUNC_W-1:0] v);
      if (v[TRUNC_W-1:NBT_OUT-1] == {(TRUNC_W-NBT_OUT+1){v[TRUNC_W-1]}})
         sat_y = v[NBT_OUT-1:0];
      else
         sat_y = {v[TRUNC_W-1], {(NBT_OUT-1){~v[TRUNC_W-1]}}};
   endfunction

   function automatic logic [NBT_ERR-1:0] sat_err(input logic [ERR_CALC_W-1:0] v);
      if (v[ERR_CALC_W-1:NBT_ERR-1] == {(ERR_CALC_W-NBT_ERR+1){v[ERR_CALC_W-1]}})
         sat_err = v[NBT_ERR-1:0];
      else
         sat_err = {v[ERR_CALC_W-1], {(NBT_ERR-1){~v[ERR_CALC_W-1]}}};
   endfunction

   // A sample right after an accepted one is dropped; baud samples are the odd ones.
   assign accept = i_reset_n & i_en_rx & i_valid & ~acc_d;
   assign baud   = accept & phase;

   // y is registered at the T0 edge, so it is computed over the window including the incoming sample.
   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      logic signed [NBT_TAPS-1:0] t_I, t_Q;
      logic signed [PROD_W-1:0]   p_ii, p_qq, p_iq, p_qi;
      assign t_I = i_taps_I[k*NBT_TAPS +: NBT_TAPS];
      assign t_Q = i_taps_Q[k*NBT_TAPS +: NBT_TAPS];
      if (k == 0) begin : g_head
         assign win_I[k] = i_data_I;
         assign win_Q[k] = i_data_Q;
      end else begin : g_body
         assign win_I[k] = sh_I[k-1];
         assign win_Q[k] = sh_Q[k-1];
      end
      assign p_ii     = PROD_W'(t_I) * PROD_W'(win_I[k]);
      assign p_qq     = PROD_W'(t_Q) * PROD_W'(win_Q[k]);
      assign p_iq     = PROD_W'(t_I) * PROD_W'(win_Q[k]);
      assign p_qi     = PROD_W'(t_Q) * PROD_W'(win_I[k]);
      assign sum_I[k] = SUM_W'(p_ii) - SUM_W'(p_qq);
      assign sum_Q[k] = SUM_W'(p_iq) + SUM_W'(p_qi);
   end

   always_comb begin
      acc_I = '0;
      acc_Q = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         acc_I = acc_I + ACC_W'(sum_I[k]);
         acc_Q = acc_Q + ACC_W'(sum_Q[k]);
      end
   end

   assign tr_I = acc_I[ACC_W-1:SHIFT];
   assign tr_Q = acc_Q[ACC_W-1:SHIFT];

   assign d_I = y_I[NBT_OUT-1] ? -ERR_CALC_W'(DEC_LVL) : ERR_CALC_W'(DEC_LVL);
   assign d_Q = y_Q[NBT_OUT-1] ? -ERR_CALC_W'(DEC_LVL) : ERR_CALC_W'(DEC_LVL);
   assign e_I = (ERR_CALC_W'(y_I) - d_I) >>> ERR_SHIFT;
   assign e_Q = (ERR_CALC_W'(y_Q) - d_Q) >>> ERR_SHIFT;

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            sh_I[k] <= '0;
            sh_Q[k] <= '0;
         end
         acc_d <= 1'b0;  phase <= 1'b0;  overrun <= 1'b0;
         y_valid <= 1'b0;  en_taps <= 1'b0;
         y_I <= '0;  y_Q <= '0;  err_I <= '0;  err_Q <= '0;
         dec_I <= 1'b0;  dec_Q <= 1'b0;
         hold_cnt <= HCNT_W'(HOLD_LEN);
      end else if (!i_en_rx) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            sh_I[k] <= '0;
            sh_Q[k] <= '0;
         end
         acc_d <= 1'b0;  phase <= 1'b0;  overrun <= 1'b0;
         y_valid <= 1'b0;  en_taps <= 1'b0;
         y_I <= '0;  y_Q <= '0;  err_I <= '0;  err_Q <= '0;
         dec_I <= 1'b0;  dec_Q <= 1'b0;
         hold_cnt <= HCNT_W'(HOLD_LEN);
      end else begin
         acc_d <= accept;
         if (i_valid && acc_d)
            overrun <= 1'b1;
         if (accept) begin
            sh_I[0] <= i_data_I;
            sh_Q[0] <= i_data_Q;
            for (int k = 1; k < NUM_TAPS; k++) begin
               sh_I[k] <= sh_I[k-1];
               sh_Q[k] <= sh_Q[k-1];
            end
            phase <= ~phase;
         end
         y_valid <= baud;
         if (baud) begin
            y_I <= sat_y(tr_I);
            y_Q <= sat_y(tr_Q);
         end
         en_taps <= y_valid && (hold_cnt == '0);
         if (y_valid) begin
            err_I <= sat_err(e_I);
            err_Q <= sat_err(e_Q);
            dec_I <= y_I[NBT_OUT-1];
            dec_Q <= y_Q[NBT_OUT-1];
            if (hold_cnt != '0)
               hold_cnt <= hold_cnt - HCNT_W'(1);
         end
      end
   end

   assign o_y_I         = y_I;
   assign o_y_Q         = y_Q;
   assign o_y_valid     = y_valid;
   assign o_save_shftrs = y_valid;
   assign o_dec_I       = dec_I;
   assign o_dec_Q       = dec_Q;
   assign o_err_I       = err_I;
   assign o_err_Q       = err_Q;
   assign o_en_shtr     = accept;
   assign o_en_taps     = en_taps;
   assign o_overrun     = overrun;

endmodule

// File: tb/tb_fse_filter.sv
// tb/tb_fse_filter.sv - directed self-checking bench for fse_filter (hold expectations follow FSE_STARTUP_HOLD_EN)
module tb_fse_filter;

   localparam int NT = 9;
   localparam int TW = 28;
`ifdef FSE_STARTUP_HOLD_EN
   localparam int HOLD = 16;
`else
   localparam int HOLD = 0;
`endif

   logic            clk = 1'b0;
   logic            i_reset_n, i_en_rx, i_valid;
   logic [7:0]      i_data_I, i_data_Q;
   logic [NT*TW-1:0] i_taps_I, i_taps_Q;
   logic [11:0]     o_y_I, o_y_Q, o_err_I, o_err_Q;
   logic            o_y_valid, o_dec_I, o_dec_Q;
   logic            o_en_shtr, o_save_shftrs, o_en_taps, o_overrun;

   int n_chk = 0, n_fail = 0, sym_cnt = 0;
   int n_shtr = 0, n_yv = 0, n_save = 0, n_taps = 0;
   bit cnt_en = 1'b0;

   always #5 clk = ~clk;

   fse_filter dut (
      .clk(clk), .i_reset_n(i_reset_n), .i_en_rx(i_en_rx), .i_valid(i_valid),
      .i_data_I(i_data_I), .i_data_Q(i_data_Q), .i_taps_I(i_taps_I), .i_taps_Q(i_taps_Q),
      .o_y_I(o_y_I), .o_y_Q(o_y_Q), .o_y_valid(o_y_valid), .o_dec_I(o_dec_I), .o_dec_Q(o_dec_Q),
      .o_err_I(o_err_I), .o_err_Q(o_err_Q), .o_en_shtr(o_en_shtr), .o_save_shftrs(o_save_shftrs),
      .o_en_taps(o_en_taps), .o_overrun(o_overrun)
   );

   always @(negedge clk) begin
      if (cnt_en) begin
         n_shtr += int'(o_en_shtr);
         n_yv   += int'(o_y_valid);
         n_save += int'(o_save_shftrs);
         n_taps += int'(o_en_taps);
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check(tag, {o_y_I, o_y_Q, o_err_I, o_err_Q, o_dec_I, o_dec_Q, o_y_valid,
                  o_en_shtr, o_save_shftrs, o_en_taps, o_overrun}, 0);
   endtask

   task automatic do_reset();
      i_valid   = 1'b0;
      i_reset_n = 1'b0;
      step();
      step();
      check_zero("reset");
      i_reset_n = 1'b1;
      sym_cnt   = 0;
      step();
   endtask

   // Non-baud sample a, gap, baud sample b, then two idle cycles covering T0+1 and T0+2.
   task automatic send_pair(input int a_i, input int a_q, input int b_i, input int b_q);
      i_valid = 1'b1; i_data_I = 8'(a_i); i_data_Q = 8'(a_q);
      @(negedge clk); check("shtr_a", o_en_shtr, 1);
      step(); i_valid = 1'b0;
      @(negedge clk); check("ysv_a", {o_y_valid, o_save_shftrs}, 0);
      step(); i_valid = 1'b1; i_data_I = 8'(b_i); i_data_Q = 8'(b_q);
      @(negedge clk); check("shtr_b", o_en_shtr, 1);
      step(); i_valid = 1'b0; sym_cnt++;
      @(negedge clk); check("t1_strobes", {o_y_valid, o_save_shftrs, o_en_taps}, 3'b110);
      step();
      @(negedge clk); check("t2_strobes", {o_y_valid, o_save_shftrs, o_en_taps}, {2'b00, sym_cnt > HOLD});
      step();
   endtask

   task automatic feed(input int n, input int x_i, input int x_q);
      repeat (n) send_pair(x_i, x_q, x_i, x_q);
   endtask

   initial begin
      i_reset_n = 1'b0; i_en_rx = 1'b1; i_valid = 1'b0;
      i_data_I = '0; i_data_Q = '0; i_taps_I = '0; i_taps_Q = '0;
      do_reset();

      // identity tap at the centre
      i_taps_I[4*TW +: TW] = 28'h200_0000;
      send_pair(64, 0, 64, 0);
      check("id_y_early", $signed(o_y_I), 0);
      check("id_err_early", $signed(o_err_I), -362);
      feed(2, 64, 0);
      check("id_y_I", $signed(o_y_I), 256);
      check("id_dec_I", o_dec_I, 0);
      check("id_err_I", $signed(o_err_I), -106);
      check("id_y_Q", $signed(o_y_Q), 0);
      check("id_err_Q", $signed(o_err_Q), -362);
      check("id_dec_Q", o_dec_Q, 0);
      feed(3, -64, 0);
      check("neg_y_I", $signed(o_y_I), -256);
      check("neg_dec_I", o_dec_I, 1);
      check("neg_err_I", $signed(o_err_I), 106);

      // smallest tap: truncation goes toward -inf
      i_taps_I[4*TW +: TW] = 28'd1;
      feed(3, -1, 0);
      check("trunc_neg_y", $signed(o_y_I), -1);
      check("trunc_neg_err", $signed(o_err_I), 361);
      feed(3, 1, 0);
      check("trunc_pos_y", $signed(o_y_I), 0);
      check("trunc_pos_err", $signed(o_err_I), -362);

      // rotation by j, then tap 1+j on x = 0.5+0.25j
      i_taps_I = '0;
      i_taps_Q[4*TW +: TW] = 28'h200_0000;
      feed(3, 64, 0);
      check("rot_y_Q", $signed(o_y_Q), 256);
      check("rot_y_I", $signed(o_y_I), 0);
      check("rot_err_Q", $signed(o_err_Q), -106);
      i_taps_I[4*TW +: TW] = 28'h200_0000;
      feed(3, 64, 32);
      check("cplx_y_I", $signed(o_y_I), 128);
      check("cplx_y_Q", $signed(o_y_Q), 384);
      check("cplx_err_I", $signed(o_err_I), -234);
      check("cplx_err_Q", $signed(o_err_Q), 22);

      // saturation
      i_taps_Q = '0;
      for (int m = 0; m < NT; m++) i_taps_I[m*TW +: TW] = 28'h7FF_FFFF;
      feed(5, 127, 0);
      check("sat_y_pos", $signed(o_y_I), 2047);
      check("sat_err_pos", $signed(o_err_I), 1685);
      check("sat_y_Q", $signed(o_y_Q), 0);
      feed(5, -128, 0);
      check("sat_y_neg", $signed(o_y_I), -2048);
      check("sat_err_neg", $signed(o_err_I), -1686);
      check("sat_dec_neg", o_dec_I, 1);

      // dense stream at minimum spacing
      i_taps_I = '0;
      do_reset();
      cnt_en = 1'b1;
      repeat (8) begin
         i_valid = 1'b1; step();
         i_valid = 1'b0; step();
      end
      step(); step(); step();
      cnt_en = 1'b0;
      check("dense_shtr", n_shtr, 8);
      check("dense_yv", n_yv, 4);
      check("dense_save", n_save, 4);
      check("dense_taps", n_taps, (4 > HOLD) ? 4 - HOLD : 0);
      check("dense_ovr", o_overrun, 0);

      // startup hold: error present even when taps are held
      do_reset();
      i_taps_I[4*TW +: TW] = 28'h200_0000;
      repeat (17) begin
         send_pair(0, 0, 0, 0);
         check("hold_err", o_err_I != 0, 1);
      end

      // back-to-back sample is dropped and flags overrun
      do_reset();
      i_taps_I = '0;
      i_taps_I[1*TW +: TW] = 28'h200_0000;
      check("ovr_pre", o_overrun, 0);
      i_valid = 1'b1; i_data_I = 8'd10; i_data_Q = 8'd0;
      @(negedge clk); check("ovr_shtr_a", o_en_shtr, 1);
      step(); i_data_I = 8'd100;
      @(negedge clk); check("ovr_shtr_b", o_en_shtr, 0);
      step(); i_valid = 1'b0;
      @(negedge clk); check("ovr_flag", o_overrun, 1); check("ovr_yv", o_y_valid, 0);
      step(); i_valid = 1'b1; i_data_I = 8'd20;
      @(negedge clk); check("ovr_shtr_c", o_en_shtr, 1);
      step(); i_valid = 1'b0;
      @(negedge clk); check("ovr_yv2", o_y_valid, 1); check("ovr_y", $signed(o_y_I), 40);
      step(); step();
      check("ovr_sticky", o_overrun, 1);
      i_en_rx = 1'b0;
      step();
      @(negedge clk); check_zero("en_rx_low");
      i_en_rx = 1'b1; sym_cnt = 0;
      step();
      send_pair(0, 0, 0, 0);

      // async reset at T0+1 kills pending strobes
      i_taps_I = '0;
      i_taps_I[4*TW +: TW] = 28'h200_0000;
      feed(3, 64, 0);
      i_valid = 1'b1; i_data_I = 8'd64; step();
      i_valid = 1'b0; step();
      i_valid = 1'b1; step();
      i_valid = 1'b0; #1;
      check("mid_pre", o_y_valid, 1);
      i_reset_n = 1'b0; #1;
      check_zero("mid_reset");
      @(negedge clk); check("mid_taps0", o_en_taps, 0);
      step();
      @(negedge clk); check("mid_taps1", o_en_taps, 0);
      i_reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
